// File: rtl/mole_spawner.sv
// Whack-a-mole spawner: raises one mole at a time from a random hole, times its
// up-window and scores hits (new rising presses on the raised hole) and misses.
module mole_spawner #(
  parameter int unsigned MIN_GAP    = 8,
  parameter int unsigned MIN_UP     = 16,
  parameter int unsigned COOL_TICKS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        tick,
  input  logic [15:0] rnd,
  input  logic [7:0]  hit,
  output logic [7:0]  mole,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic [7:0]  hit_count,
  output logic [7:0]  miss_count,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    UP   = 2'd2,
    COOL = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [7:0] hit_q;
  logic [2:0] last_hole_q, last_hole_d;
  logic       last_valid_q, last_valid_d;
  logic       hit_pulse_d, miss_pulse_d;
  logic       hit_inc, miss_inc;

  logic [7:0] press;
  logic       expired;
  logic [7:0] gap_load;
  logic [7:0] up_load;
  logic [2:0] cand;
  logic [2:0] sel_hole;

  // Bits of the random word that no decision depends on.
  logic unused_rnd;
  assign unused_rnd = ^{rnd[11:9], rnd[3]};

  assign press    = hit & ~hit_q;
  assign expired  = tick && (timer_q == 8'd0);
  assign gap_load = 8'(MIN_GAP) + {4'd0, rnd[15:12]};
  assign up_load  = 8'(MIN_UP) + {3'd0, rnd[8:4]};
  assign cand     = rnd[2:0];
  // Never show the same hole twice in a row; the 3-bit add wraps 7 to 0.
  assign sel_hole = (last_valid_q && (cand == last_hole_q)) ? cand + 3'd1 : cand;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    last_hole_d  = last_hole_q;
    last_valid_d = last_valid_q;
    hit_pulse_d  = 1'b0;
    miss_pulse_d = 1'b0;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;

    if (!enable) begin
      state_d      = IDLE;
      timer_d      = 8'd0;
      last_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = GAP;
          timer_d = gap_load;
        end
        GAP: begin
          if (expired) begin
            state_d      = UP;
            timer_d      = up_load;
            last_hole_d  = sel_hole;
            last_valid_d = 1'b1;
          end else if (tick) begin
            timer_d = timer_q - 8'd1;
          end
        end
        UP: begin
          // A press wins over a simultaneous timeout.
          if (press[last_hole_q]) begin
            state_d     = COOL;
            timer_d     = 8'(COOL_TICKS);
            hit_pulse_d = 1'b1;
            hit_inc     = 1'b1;
          end else if (expired) begin
            state_d      = COOL;
            timer_d      = 8'(COOL_TICKS);
            miss_pulse_d = 1'b1;
            miss_inc     = 1'b1;
          end else if (tick) begin
            timer_d = timer_q - 8'd1;
          end
        end
        COOL: begin
          if (expired) begin
            state_d = GAP;
            timer_d = gap_load;
          end else if (tick) begin
            timer_d = timer_q - 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = 8'd0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      timer_q      <= 8'd0;
      hit_q        <= 8'd0;
      last_hole_q  <= 3'd0;
      last_valid_q <= 1'b0;
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
      hit_count    <= 8'd0;
      miss_count   <= 8'd0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      hit_q        <= hit;
      last_hole_q  <= last_hole_d;
      last_valid_q <= last_valid_d;
      hit_pulse    <= hit_pulse_d;
      miss_pulse   <= miss_pulse_d;
      if (hit_inc && (hit_count != 8'hFF)) begin
        hit_count <= hit_count + 8'd1;
      end
      if (miss_inc && (miss_count != 8'hFF)) begin
        miss_count <= miss_count + 8'd1;
      end
    end
  end

  // Decoded from the state register so an asynchronous reset drops the mole at once.
  always_comb begin
    mole = 8'd0;
    if (state_q == UP) begin
      mole[last_hole_q] = 1'b1;
    end
  end

  assign state = state_q;

endmodule
